// File: rtl/load_store_unit.sv
// Memory-access stage: RISC-V byte/half/word loads and stores against an internal
// little-endian word RAM with a fixed ACCESS latency and a one-cycle response pulse.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        fault,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [4:0]      rd_q;

    logic            resp_we_q;
    logic            fault_q;
    logic [31:0]     resp_data_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic            misalign;
    logic            illegal;
    logic            out_of_range;
    logic            fault_c;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [3:0]      byte_en;
    logic [31:0]     wr_lanes;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_data;

    assign accept     = req_valid && (state_q == IDLE);
    assign commit     = (state_q == ACCESS) && (cnt_q == '0);
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_we    = resp_we_q;
    assign fault      = fault_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
        end
    end

    // funct3[1:0] encodes access size for both loads and stores (00 byte, 01 half, 10 word)
    always_comb begin
        misalign     = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        illegal      = is_store_q ? (funct3_q > 3'd2)
                                  : ((funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11));
        out_of_range = (addr_q[31:AW+2] != '0);
        fault_c      = misalign || illegal || out_of_range;
    end

    assign word_idx = addr_q[AW+1:2];
    assign lane     = addr_q[1:0];

    always_comb begin
        byte_en  = '0;
        wr_lanes = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = wdata_q;
            end
        endcase
    end

    // RAM is deliberately outside the reset domain so committed data survives reset
    always_ff @(posedge clk) begin
        if (commit && is_store_q && !fault_c) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_we_q   <= 1'b0;
            fault_q     <= 1'b0;
            resp_data_q <= '0;
        end else if (commit) begin
            resp_we_q   <= !is_store_q && !fault_c && (rd_q != 5'd0);
            fault_q     <= fault_c;
            resp_data_q <= (!is_store_q && !fault_c) ? load_data : 32'd0;
        end else if (state_q == RESP) begin
            resp_we_q   <= 1'b0;
            fault_q     <= 1'b0;
            resp_data_q <= '0;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits directly downstream of the execute stage: it takes the ALU result as a byte address, together with the rs2 store data and destination register, and performs RISC-V byte, halfword and word loads and stores against an internal word-organised data RAM with a fixed multi-cycle access latency. It returns load data, sign- or zero-extended, to write-back through a one-cycle response pulse and flags misaligned, illegal or out-of-range accesses.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, minimum 4.
- LATENCY, 2: cycles spent in ACCESS; minimum 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute presents a memory request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address (ALU_out).
- req_wdata  in  32  store data (rs2 value); low byte or halfword used for SB/SH.
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_we  out  1  register write enable; valid with resp_valid.
- resp_rd  out  5  destination register; valid with resp_valid.
- resp_data  out  32  extended load data; 0 for stores and faults.
- fault  out  1  access fault; valid with resp_valid.
- busy  out  1  high in ACCESS or RESP.

## Operation
- The RAM is little-endian. Word index is req_addr[log2(DEPTH_WORDS)+1:2]; byte lane is req_addr[1:0].
- A request is accepted on an edge where req_valid & req_ready. The unit latches req_is_store, req_funct3, req_addr, req_wdata and req_rd at that edge.
- A fault is any of: misalignment (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]≠0); an illegal funct3 (load 011, 110, 111; store 011 through 111); or req_addr ≥ 4·DEPTH_WORDS.
- FSM states are IDLE, ACCESS and RESP:
  - IDLE: on acceptance, go to ACCESS with cnt=LATENCY-1. A faulting request goes to ACCESS too, so latency is uniform.
  - ACCESS: on each edge, if cnt≠0 decrement it; otherwise perform the access and go to RESP.
  - RESP: resp_valid=1 for exactly this cycle, then return to IDLE. Write-back never stalls.
- Access rules:
  - Stores: write only the addressed byte lanes (SB 1 lane, SH 2 lanes, SW 4 lanes). All other bytes are untouched.
  - Loads: select the addressed byte or halfword. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Faults: no RAM write, resp_data=0, fault=1, resp_we=0.
- resp_we = load & ~fault & (rd≠0). resp_rd always echoes the latched rd.
- RAM contents are not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, resp_valid=0, resp_we=0, fault=0, resp_rd=0, resp_data=0, cnt=0.
- Request accepted at edge E: the RAM write or read happens at edge E+LATENCY. resp_valid is high in the cycle after edge E+LATENCY, i.e. it is sampled at edge E+LATENCY+1.
- Throughput is one request per LATENCY+2 cycles. req_ready is low from edge E until the RESP→IDLE edge.
- req_ready is registered (state==IDLE) and does not depend combinationally on req_valid.
- A load issued after a store sees the store data; there is no forwarding hazard, because accesses are serialised.
- Reset asserted mid-ACCESS returns the FSM to IDLE immediately with no response. A store not yet committed at its commit edge is dropped; a committed store persists.
- Request inputs are ignored while req_ready=0.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 rd=5 → second response: resp_data=0xDEADBEEF, resp_we=1, resp_rd=5, fault=0; each resp_valid arrives LATENCY+1 cycles after its acceptance edge.
- SB addr 0x22 data 0x000000F0 over a word of 0; then LB 0x22 → 0xFFFFFFF0; LBU 0x22 → 0x000000F0; LW 0x20 → 0x00F00000.
- LW addr 0x02, then SH addr 0x11 → each gives fault=1, resp_we=0, resp_data=0; a following LW 0x10 confirms the RAM is unchanged.
- LW addr 4·DEPTH_WORDS, and a load with funct3=011 → fault=1, no RAM write, req_ready returns high after RESP.
- SW issued, then reset asserted after one ACCESS cycle with LATENCY=3 → outputs take reset values immediately, no resp_valid; a subsequent LW shows the old data.
- req_valid held high for three back-to-back LW with rd=0 → requests accepted every LATENCY+2 cycles, resp_we=0 each time, req_ready low throughout busy.
